// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types for the data-memory responder
// Holds the FSM state enum, the wait counter type and the request/response control structs.
package dmem_responder_pkg;
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef struct packed {
        logic we;
        logic fault;
    } req_t;
    typedef struct packed {
        logic valid;
        logic err;
    } rsp_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between a requester and the data memory
// Ports: req_valid/req_ready/req_we/req_mask/req_addr/req_wdata, rsp_valid/rsp_ready/rsp_rdata/rsp_err
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [DATA_WIDTH/8-1:0] req_mask;
    logic [DATA_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    modport master (
        output req_valid, req_we, req_mask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_mask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_sram.sv
// dmem_sram: single-port word array with synchronous read and per-byte write enables
// Ports: clk; re (read enable); be (byte write enables); idx (word index); wdata; rdata (registered)
module dmem_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                       clk,
    input  logic                       re,
    input  logic [DATA_WIDTH/8-1:0]    be,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with fixed wait states and fault checking
// Ports: clk, rst (sync, active-high); bus (slave modport) carrying the req_* and rsp_* handshakes
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DMEM_SZ_IN_KB = 1,
    parameter int WAIT_STATES   = 1
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int MW    = DATA_WIDTH / 8;
    localparam int DEPTH = DMEM_SZ_IN_KB * 1024 / MW;
    localparam int AW    = $clog2(DEPTH);

    state_t                state;
    cnt_t                  cnt;
    req_t                  req_in, req_q, req_c;
    rsp_t                  rsp_q;
    logic [AW-1:0]         idx_q, idx_c;
    logic [MW-1:0]         mask_q, mask_c, be;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_c, sram_q;
    logic                  hs, go, re;

    // Unaligned accesses are only legal as the single byte at that offset or the upper halfword.
    function automatic logic mask_legal(input logic [1:0] off, input logic [MW-1:0] m);
        return off == 2'd0 || m == (MW'(1) << off) || (off == 2'd2 && m == (MW'(3) << 2));
    endfunction

    assign hs     = bus.req_valid && state == IDLE;
    assign req_in = req_t'{we: bus.req_we,
                           fault: bus.req_addr >= DATA_WIDTH'(DEPTH * 4) ||
                                  !mask_legal(bus.req_addr[1:0], bus.req_mask)};

    // With zero wait states the array is accessed on the accept edge, so the live request feeds it.
    assign req_c   = state == IDLE ? req_in : req_q;
    assign idx_c   = state == IDLE ? bus.req_addr[AW+1:2] : idx_q;
    assign mask_c  = state == IDLE ? bus.req_mask : mask_q;
    assign wdata_c = state == IDLE ? bus.req_wdata : wdata_q;
    assign go      = !rst && (state == IDLE ? hs && WAIT_STATES == 0 : state == WAIT && cnt == '0);
    assign re      = go && !req_c.we && !req_c.fault;
    assign be      = go && req_c.we && !req_c.fault ? mask_c : '0;

    dmem_sram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .re    (re),
        .be    (be),
        .idx   (idx_c),
        .wdata (wdata_c),
        .rdata (sram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rsp_q <= '0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    req_q   <= req_in;
                    idx_q   <= bus.req_addr[AW+1:2];
                    mask_q  <= bus.req_mask;
                    wdata_q <= bus.req_wdata;
                    cnt     <= cnt_t'(WAIT_STATES - 1);
                    state   <= go ? RESP : WAIT;
                    rsp_q   <= rsp_t'{valid: go, err: go && req_in.fault};
                end
                WAIT: if (go) begin
                    state <= RESP;
                    rsp_q <= rsp_t'{valid: 1'b1, err: req_q.fault};
                end else begin
                    cnt <= cnt - cnt_t'(1);
                end
                default: if (bus.rsp_ready) begin
                    state <= IDLE;
                    rsp_q <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = rsp_q.valid;
    assign bus.rsp_err   = rsp_q.err;
    // The array output register only changes on a read, so gating it holds load data stable in RESP.
    assign bus.rsp_rdata = rsp_q.valid && !req_q.we && !rsp_q.err ? sram_q : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized bench for dmem_responder with WAIT_STATES=1 and WAIT_STATES=0 instances
module tb_dmem_responder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        sel = 1'b0, valid = 1'b0, we = 1'b0, rready = 1'b1;
    logic [3:0]  mask = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        rq_ready, rs_valid, rs_err;
    logic [31:0] rs_rdata;
    int          cyc = 0, n_chk = 0, n_fail = 0;
    logic [31:0] mm [2][256];
    logic [31:0] rd;
    int          acc, prev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if b1 ();
    dmem_responder_if b0 ();
    dmem_responder #(.WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    assign b1.req_valid = valid && !sel;
    assign b0.req_valid = valid && sel;
    assign b1.req_we    = we;
    assign b0.req_we    = we;
    assign b1.req_mask  = mask;
    assign b0.req_mask  = mask;
    assign b1.req_addr  = addr;
    assign b0.req_addr  = addr;
    assign b1.req_wdata = wdata;
    assign b0.req_wdata = wdata;
    assign b1.rsp_ready = rready;
    assign b0.rsp_ready = rready;
    assign rq_ready = sel ? b0.req_ready : b1.req_ready;
    assign rs_valid = sel ? b0.rsp_valid : b1.rsp_valid;
    assign rs_err   = sel ? b0.rsp_err   : b1.rsp_err;
    assign rs_rdata = sel ? b0.rsp_rdata : b1.rsp_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction on DUT s (0: one wait state, 1: none), checked against the word model.
    task automatic xact(input logic s, input logic w, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] d, input int hold, output logic [31:0] r, output int t);
        int          n;
        logic        f, legal;
        logic [1:0]  o;
        logic [31:0] exp;
        o     = a[1:0];
        legal = o == 2'd0 || (o == 2'd1 && m == 4'b0010) ||
                (o == 2'd2 && (m == 4'b0100 || m == 4'b1100)) || (o == 2'd3 && m == 4'b1000);
        f     = a >= 32'd1024 || !legal;
        exp   = (w || f) ? 32'd0 : mm[s][a[9:2]];
        @(negedge clk);
        sel = s; valid = 1'b1; we = w; mask = m; addr = a; wdata = d; rready = hold == 0;
        n = 0;
        while (!rq_ready && n < 20) begin @(negedge clk); n++; end
        t = cyc;
        @(negedge clk);
        valid = 1'b0;
        n = 1;
        while (!rs_valid && n < 40) begin @(negedge clk); n++; end
        check("latency", 32'(n), s ? 32'd1 : 32'd2);
        r = rs_rdata;
        check("rsp_err", 32'(rs_err), 32'(f));
        check("rsp_rdata", r, exp);
        if (hold > 0) begin
            valid = 1'b1; we = 1'b1; mask = 4'hF; addr = a ^ 32'h4; wdata = ~d;
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", 32'(rs_valid), 32'd1);
                check("hold_rdata", rs_rdata, r);
                check("hold_ready", 32'(rq_ready), 32'd0);
            end
            valid = 1'b0; rready = 1'b1;
            @(negedge clk);
            check("release", 32'(rs_valid), 32'd0);
        end
        if (w && !f)
            for (int b = 0; b < 4; b++)
                if (m[b]) mm[s][a[9:2]][b*8 +: 8] = d[b*8 +: 8];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready1", 32'(b1.req_ready), 32'd1);
        check("rst_valid1", 32'(b1.rsp_valid), 32'd0);
        check("rst_rdata1", b1.rsp_rdata, 32'd0);
        check("rst_err1",   32'(b1.rsp_err), 32'd0);
        check("rst_ready0", 32'(b0.req_ready), 32'd1);
        check("rst_valid0", 32'(b0.rsp_valid), 32'd0);

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++)
                xact(s[0], 1'b1, 4'hF, 32'(i * 4), $urandom, 0, rd, acc);

        xact(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, rd, acc);
        check("store_rdata_zero", rd, 32'd0);
        xact(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 0, rd, acc);
        check("load_deadbeef", rd, 32'hDEADBEEF);
        xact(1'b0, 1'b1, 4'b0010, 32'h11, 32'h0000AA00, 0, rd, acc);
        xact(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 0, rd, acc);
        check("byte_store", rd, 32'hDEADAAEF);
        xact(1'b0, 1'b0, 4'hF, 32'h400, 32'h0, 0, rd, acc);
        check("oob_load_rdata", rd, 32'd0);
        check("oob_load_err", 32'(rs_err), 32'd1);
        xact(1'b0, 1'b1, 4'hF, 32'h400, 32'hFFFFFFFF, 0, rd, acc);
        xact(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 0, rd, acc);
        xact(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 4, rd, acc);
        check("held_load", rd, 32'hDEADAAEF);
        xact(1'b0, 1'b1, 4'h0, 32'h10, 32'h01234567, 0, rd, acc);
        check("mask0_err", 32'(rs_err), 32'd0);
        xact(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 0, rd, acc);
        check("mask0_nochange", rd, 32'hDEADAAEF);

        xact(1'b0, 1'b1, 4'hF, 32'h20, 32'h12345678, 0, rd, acc);
        @(negedge clk);
        sel = 1'b0; valid = 1'b1; we = 1'b1; mask = 4'hF; addr = 32'h20; wdata = 32'hCAFEF00D;
        @(negedge clk);
        valid = 1'b0; rst = 1'b1;
        check("wait_no_rsp", 32'(rs_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_wait_ready", 32'(rq_ready), 32'd1);
        check("rst_wait_valid", 32'(rs_valid), 32'd0);
        xact(1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 0, rd, acc);
        check("rst_no_write", rd, 32'h12345678);

        prev = 0;
        for (int i = 0; i < 8; i++) begin
            xact(1'b1, i[0], 4'hF, 32'($urandom_range(0, 255) * 4), $urandom, 0, rd, acc);
            if (i > 0) check("b2b_spacing", 32'(acc - prev), 32'd2);
            prev = acc;
        end

        repeat (300) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = r == 0 ? 32'd1024 + $urandom_range(0, 60000) : r == 1 ? 32'hFFFFFFFC : $urandom_range(0, 1023);
            xact(1'($urandom), 1'($urandom), 4'($urandom), a, $urandom,
                 $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0, rd, acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter DMEM_SZ_IN_KB, default 1, storage size in KB (DEPTH = DMEM_SZ_IN_KB*1024/(DATA_WIDTH/8) words).
REQ-003 SHALL have parameter WAIT_STATES, default 1, extra cycles between accept and response (0..15).
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  responder can accept a request.
REQ-008 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_mask  in  DATA_WIDTH/8  byte enables for stores.
REQ-010 SHALL have port req_addr  in  DATA_WIDTH  byte address.
REQ-011 SHALL have port req_wdata  in  DATA_WIDTH  store data, byte lanes aligned to mask.
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  requester accepts response.
REQ-014 SHALL have port rsp_rdata  out  DATA_WIDTH  load data, full word.
REQ-015 SHALL have port rsp_err  out  1  access faulted.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; one outstanding request maximum.
REQ-017 req_ready SHALL equal (state==IDLE), no combinational path from req_valid.
REQ-018 Handshake SHALL occur when req_valid && req_ready; addr/we/mask/wdata captured in that cycle.
REQ-019 IDLE -> WAIT on handshake if WAIT_STATES>0, loading counter with WAIT_STATES-1; IDLE -> RESP directly if WAIT_STATES==0.
REQ-020 WAIT SHALL decrement counter each cycle; WAIT -> RESP when counter==0.
REQ-021 Array access (read or masked write) SHALL occur on the cycle entering RESP; rsp_valid asserts first cycle in RESP, i.e. accept cycle N -> rsp_valid at N+1+WAIT_STATES.
REQ-022 In RESP, rsp_valid, rsp_rdata, rsp_err SHALL stay stable until rsp_ready; RESP -> IDLE on rsp_valid && rsp_ready; no new accept in that same cycle.
REQ-023 Word index SHALL be captured addr[log2(DEPTH)+1:2]; byte offset addr[1:0].
REQ-024 Fault SHALL be raised when addr >= DEPTH*4 (out of range) or addr[1:0]!=0 while mask is not a legal halfword/byte pattern for that offset; faulted stores SHALL not write, faulted loads SHALL return rsp_rdata=0; rsp_err=1.
REQ-025 Stores SHALL update only bytes with mask bit set; rsp_rdata for a store SHALL be 0.
REQ-026 Loads SHALL return the full stored word; sign/zero extension is the requester's responsibility.
REQ-027 Store with req_mask==0 SHALL complete normally with no array change, rsp_err=0.

Reset
REQ-028 On rst: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 from the next cycle.
REQ-029 rst during WAIT SHALL abandon the pending request with no array write; rst during RESP SHALL drop the response.
REQ-030 Array contents SHALL NOT be cleared by rst.

Structure
REQ-031 Package dmem_responder_pkg SHALL hold the state enum type and the request/response struct types.
REQ-032 Storage SHALL be a sub-module dmem_sram (synchronous read, per-byte write enable), instantiated once.

Verification
REQ-033 WAIT_STATES=1: store addr 0x10 data 0xDEADBEEF mask 4'b1111 accepted cycle 5 -> rsp_valid cycle 7, rsp_err=0; load 0x10 -> rsp_rdata 0xDEADBEEF.
REQ-034 Byte store addr 0x11 data 0x0000AA00 mask 4'b0010 over 0xDEADBEEF -> subsequent load 0x10 returns 0xDEADAAEF.
REQ-035 Load addr 0x400 (DMEM_SZ_IN_KB=1) -> rsp_err=1, rsp_rdata=0; no array change.
REQ-036 rsp_ready held low 4 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; a req_valid during that time not accepted.
REQ-037 rst asserted in WAIT of store to 0x20 (prior 0x12345678) -> state IDLE, later load 0x20 returns 0x12345678.
REQ-038 WAIT_STATES=0: accept cycle N -> rsp_valid cycle N+1; back-to-back requests complete every 2 cycles with rsp_ready=1.
